// File: rtl/led_blink_arbiter.sv
// -----------------------------------------------------------------------------
// led_blink_arbiter
//   Shares one board LED between NUM_REQ requesters. A round-robin arbiter
//   picks one requester at a time; a sequencer then blinks the LED the
//   requested number of times. Each on and off phase lasts HALF_PERIOD clocks.
//
// Parameters
//   NUM_REQ      number of requesters (1..8)
//   HALF_PERIOD  clk cycles per LED on phase and per off phase (>=1)
//   CNT_W        width of each requester's blink count
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req        in   level request, one bit per requester
//   blink_cnt  in   blink counts; requester i uses [i*CNT_W +: CNT_W]
//   grant      out  one-hot, registered, high for the whole sequence
//   done       out  one-cycle pulse to the granted requester at sequence end
//   busy       out  high while a sequence is in progress
//   led        out  LED drive, registered, active-high
//
// Build option
//   LED_ARB_HEARTBEAT_EN : while idle, led toggles every 2*HALF_PERIOD cycles.
//                          The heartbeat counter is cleared while busy.
// -----------------------------------------------------------------------------
module led_blink_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HALF_PERIOD = 24000000,
   parameter int CNT_W       = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] blink_cnt,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic                     led
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PRE_W = $clog2(HALF_PERIOD + 1);
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(HALF_PERIOD - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     winner_q, winner_d;
   logic [PRE_W-1:0]     presc_q, presc_d;
   logic [CNT_W-1:0]     remaining_q, remaining_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 led_q, led_d;

   logic [PTR_W-1:0]     win;
   logic                 win_vld;
   logic [CNT_W-1:0]     win_cnt;

`ifdef LED_ARB_HEARTBEAT_EN
   localparam int HB_W = $clog2(2 * HALF_PERIOD + 1);
   localparam logic [HB_W-1:0] HB_TC = HB_W'(2 * HALF_PERIOD - 1);
   logic [HB_W-1:0]      hb_q, hb_d;
`endif

   // Round-robin search starting at rr_ptr. The loop runs from the farthest
   // offset down so the nearest requester is the last one to be assigned.
   always_comb begin
      int idx;
      idx     = 0;
      win     = '0;
      win_vld = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx]) begin
            win     = PTR_W'(idx);
            win_vld = 1'b1;
         end
      end
   end

   assign win_cnt = blink_cnt[int'(win) * CNT_W +: CNT_W];

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      winner_d    = winner_q;
      presc_d     = presc_q;
      remaining_d = remaining_q;
      grant_d     = grant_q;
      led_d       = led_q;
`ifdef LED_ARB_HEARTBEAT_EN
      // Cleared unless idling with no request, so the heartbeat restarts
      // from zero after every sequence.
      hb_d        = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               winner_d    = win;
               grant_d     = NUM_REQ'(1) << win;
               remaining_d = win_cnt;
               presc_d     = '0;
               if (win_cnt != '0) begin
                  state_d = S_ON;
                  led_d   = 1'b1;
               end else begin
                  state_d = S_DONE;
                  led_d   = 1'b0;
               end
            end else begin
`ifdef LED_ARB_HEARTBEAT_EN
               if (hb_q == HB_TC) begin
                  hb_d  = '0;
                  led_d = ~led_q;
               end else begin
                  hb_d  = hb_q + 1'b1;
               end
`else
               led_d = 1'b0;
`endif
            end
         end
         S_ON: begin
            if (presc_q == PRE_TC) begin
               presc_d = '0;
               led_d   = 1'b0;
               state_d = S_OFF;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         S_OFF: begin
            if (presc_q == PRE_TC) begin
               presc_d     = '0;
               remaining_d = remaining_q - 1'b1;
               // remaining is >=1 here, so this is the "reaches zero" test.
               if (remaining_q == CNT_W'(1)) begin
                  state_d = S_DONE;
                  led_d   = 1'b0;
               end else begin
                  state_d = S_ON;
                  led_d   = 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         S_DONE: begin
            grant_d  = '0;
            led_d    = 1'b0;
            state_d  = S_IDLE;
            rr_ptr_d = (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         winner_q    <= '0;
         presc_q     <= '0;
         remaining_q <= '0;
         grant_q     <= '0;
         led_q       <= 1'b0;
`ifdef LED_ARB_HEARTBEAT_EN
         hb_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         winner_q    <= winner_d;
         presc_q     <= presc_d;
         remaining_q <= remaining_d;
         grant_q     <= grant_d;
         led_q       <= led_d;
`ifdef LED_ARB_HEARTBEAT_EN
         hb_q        <= hb_d;
`endif
      end
   end

   assign grant = grant_q;
   assign led   = led_q;
   assign busy  = (state_q != S_IDLE);
   // DONE lasts one cycle, so gating the registered grant gives the pulse.
   assign done  = (state_q == S_DONE) ? grant_q : '0;

endmodule
